// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_e;

  localparam int RES_DEF        = 8;
  localparam int NCH_DEF        = 4;
  localparam int SAMPLE_CYC_DEF = 4;
  localparam int SETTLE_CYC_DEF = 1;

  // Width of a counter that runs 0..n-1 (sample phase and bit period).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Request/result port of the SAR controller; master = host, slave = controller.
interface sar_adc_ctrl_if #(
  parameter int RES = 8,
  parameter int CHW = 2
);
  logic           start;
  logic           scan;
  logic [CHW-1:0] ch_sel;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [RES-1:0] out_data;
  logic [CHW-1:0] out_ch;

  modport master (output start, scan, ch_sel, out_ready,
                  input  busy, out_valid, out_data, out_ch);
  modport slave  (input  start, scan, ch_sel, out_ready,
                  output busy, out_valid, out_data, out_ch);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample, binary search, tagged valid/ready results, scan mode.
// Optional 4x oversampling per channel under `define SAR_OVERSAMPLE_EN.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int RES        = RES_DEF,
  parameter int NCH        = NCH_DEF,
  parameter int CHW        = $clog2(NCH),
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cmp_in_i,
  output logic [RES-1:0] dac_code_o,
  output logic [CHW-1:0] mux_sel_o,
  output logic           sample_en_o,
  sar_adc_ctrl_if.slave  bus
);
  localparam int CW = cnt_w((SAMPLE_CYC > SETTLE_CYC + 2) ? SAMPLE_CYC : SETTLE_CYC + 2);
  localparam int KW = cnt_w(RES);
  localparam logic [CW-1:0]  SMP_LAST = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(SETTLE_CYC + 1);
  localparam logic [KW-1:0]  K_TOP    = KW'(RES - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [RES-1:0] code_q, code_d;
  logic [CHW-1:0] mux_q, mux_d, och_q, och_d;
  logic [RES-1:0] od_q, od_d;
  logic           scan_q, scan_d, busy_q, busy_d, ov_q, ov_d;
  logic           cmp_s;
`ifdef SAR_OVERSAMPLE_EN
  logic [1:0]     os_q, os_d;
  logic [RES+1:0] acc_q, acc_d;
`endif

  sync_2ff #(.W(1)) u_cmp_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(cmp_in_i), .q_o(cmp_s));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      code_q  <= '0;
      mux_q   <= '0;
      och_q   <= '0;
      od_q    <= '0;
      scan_q  <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
      os_q    <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      code_q  <= code_d;
      mux_q   <= mux_d;
      och_q   <= och_d;
      od_q    <= od_d;
      scan_q  <= scan_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
`ifdef SAR_OVERSAMPLE_EN
      os_q    <= os_d;
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    code_d  = code_q;
    mux_d   = mux_q;
    och_d   = och_q;
    od_d    = od_q;
    scan_d  = scan_q;
    busy_d  = busy_q;
    ov_d    = ov_q;
`ifdef SAR_OVERSAMPLE_EN
    os_d    = os_q;
    acc_d   = acc_q;
`endif
    if (ov_q && bus.out_ready) ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        code_d = '0;
        if (bus.start) begin
          scan_d  = bus.scan;
          mux_d   = bus.scan ? '0 : bus.ch_sel;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        code_d = '0;
        if (cnt_q == SMP_LAST) begin
          cnt_d   = '0;
          k_d     = K_TOP;
          code_d  = {1'b1, {(RES-1){1'b0}}};
          state_d = CONVERT;
        end else cnt_d = cnt_q + 1'b1;
      end
      CONVERT: begin
        // cmp_s lags dac_code by the synchroniser depth; the bit period covers it
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!cmp_s) code_d[k_q] = 1'b0;
          if (k_q != '0) begin
            code_d[k_q - 1'b1] = 1'b1;
            k_d = k_q - 1'b1;
          end else begin
`ifdef SAR_OVERSAMPLE_EN
            acc_d   = acc_q + {2'b00, code_d};
            os_d    = os_q + 2'd1;
            state_d = (os_q == 2'd3) ? DONE : SAMPLE;
`else
            state_d = DONE;
`endif
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        if (!ov_q || bus.out_ready) begin
          ov_d  = 1'b1;
          och_d = mux_q;
`ifdef SAR_OVERSAMPLE_EN
          od_d  = acc_q[RES+1:2];
          acc_d = '0;
`else
          od_d  = code_q;
`endif
          if (scan_q && mux_q != CH_LAST) begin
            mux_d   = mux_q + 1'b1;
            state_d = SAMPLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_en_o   = (state_q == SAMPLE);
    dac_code_o    = (state_q == CONVERT || state_q == DONE) ? code_q : '0;
    mux_sel_o     = mux_q;
    bus.busy      = busy_q;
    bus.out_valid = ov_q;
    bus.out_data  = od_q;
    bus.out_ch    = och_q;
  end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Randomised bench for sar_adc_ctrl with a comparator model and result scoreboard.
module tb_sar_adc_ctrl;
  localparam int RES = 8, NCH = 4, CHW = 2, SAMPLE_CYC = 4, SETTLE_CYC = 1;
`ifdef SAR_OVERSAMPLE_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int LAT = 2 + NCONV * (SAMPLE_CYC + RES * (SETTLE_CYC + 2));
  localparam int FS  = (1 << RES) - 1;

  logic clk = 1'b0, rst, cmp_in, sample_en;
  logic [RES-1:0] dac_code;
  logic [CHW-1:0] mux_sel;

  sar_adc_ctrl_if #(.RES(RES), .CHW(CHW)) bus ();

  sar_adc_ctrl #(.RES(RES), .NCH(NCH), .CHW(CHW), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk_i(clk), .rst_i(rst), .cmp_in_i(cmp_in), .dac_code_o(dac_code),
    .mux_sel_o(mux_sel), .sample_en_o(sample_en), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int vin [NCH];
  int n_samp = 0;
  logic se_prev = 1'b0;
  int exp_q[$];
  int mux_q[$];
`ifdef SAR_OVERSAMPLE_EN
  int dith [4] = '{0, 1, 1, 2};
`endif

  // Comparator: 1 while the (dithered) channel voltage is at or above the DAC level
  always_comb begin
`ifdef SAR_OVERSAMPLE_EN
    cmp_in = (vin[mux_sel] + dith[(n_samp + 3) % 4]) >= int'(dac_code);
`else
    cmp_in = vin[mux_sel] >= int'(dac_code);
`endif
  end

  function automatic int exp_val(input int v);
    int s = 0;
`ifdef SAR_OVERSAMPLE_EN
    for (int i = 0; i < 4; i++) s += (v + dith[i] > FS) ? FS : v + dith[i];
    return s >> 2;
`else
    s = (v > FS) ? FS : v;
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    se_prev <= sample_en;
    if (rst) n_samp <= 0;
    else if (sample_en && !se_prev) begin
      n_samp <= n_samp + 1;
      mux_q.push_back(int'(mux_sel));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("out_extra", exp_q.size(), 1);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("out_data", int'(bus.out_data), e & 16'hFFFF);
        chk("out_ch", int'(bus.out_ch), e >> 16);
      end
    end
  end

  task automatic go(input logic sc, input int ch);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.scan = sc; bus.ch_sel = CHW'(ch);
    if (sc) for (int c = 0; c < NCH; c++) exp_q.push_back((c << 16) | exp_val(vin[c]));
    else exp_q.push_back((ch << 16) | exp_val(vin[ch]));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int t = 0;
    while ((bus.busy || bus.out_valid || exp_q.size() != 0) && t < lim) begin
      @(negedge clk); t++;
    end
    chk({tag, "_in_time"}, int'(t < lim), 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bsy1, nres, drops, t;
    int bvals [4] = '{'h00, 'hFF, 'h80, 'h1FF};
    rst = 1'b1; bus.start = 1'b0; bus.scan = 1'b0; bus.ch_sel = '0; bus.out_ready = 1'b1;
    vin = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dac", int'(dac_code), 0);
    chk("rst_mux", int'(mux_sel), 0);
    chk("rst_sample_en", int'(sample_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_ch", int'(bus.out_ch), 0);
    @(posedge clk); #1 rst = 1'b0;

    // single conversion with latency measurement
    vin[2] = 'hA5;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.scan = 1'b0; bus.ch_sel = 2'd2;
    exp_q.push_back((2 << 16) | exp_val('hA5));
    lat = 0; bsy1 = 0;
    while (lat < LAT + 20) begin
      @(negedge clk);
      if (lat == 1) bsy1 = int'(bus.busy);
      if (bus.out_valid) break;
      if (lat == 0) begin @(posedge clk); #1 bus.start = 1'b0; end
      lat++;
    end
    chk("latency", lat, LAT);
    chk("busy_after_start", bsy1, 1);
    chk("single_data", int'(bus.out_data), exp_val('hA5));
    chk("single_ch", int'(bus.out_ch), 2);
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("valid_after_accept", int'(bus.out_valid), 0);
    wait_done("single", 50);

    // boundary codes then random singles
    for (int i = 0; i < 4; i++) begin
      vin[i % NCH] = bvals[i];
      go(1'b0, i % NCH);
      wait_done("boundary", LAT + 20);
    end
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < NCH; c++) vin[c] = $urandom_range(0, FS);
      go(1'b0, $urandom_range(0, NCH - 1));
      wait_done("rand_single", LAT + 20);
    end

    // scan with fixed levels: order, mux sequence, busy held
    vin = '{'h10, 'h20, 'h30, 'h40};
    mux_q.delete();
    go(1'b1, 2);
    nres = 0; drops = 0; t = 0;
    while (nres < NCH && t < NCH * LAT + 50) begin
      @(negedge clk); t++;
      if (bus.out_valid) nres++;
      if (!bus.busy && nres < NCH) drops++;
    end
    chk("scan_results", nres, NCH);
    chk("scan_busy_held", drops, 0);
    @(negedge clk);
    chk("scan_busy_end", int'(bus.busy), 0);
    wait_done("scan", 50);
    chk("scan_mux_len", mux_q.size(), NCH * NCONV);
    for (int i = 0; i < mux_q.size(); i++) chk("scan_mux_seq", mux_q[i], i / NCONV);

    // backpressure: first result held, channel 1 stalls in DONE
    @(posedge clk); #1 bus.out_ready = 1'b0;
    go(1'b1, 0);
    repeat (2 * LAT + 20) @(negedge clk);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_data", int'(bus.out_data), exp_val('h10));
    chk("bp_mux", int'(mux_sel), 1);
    chk("bp_sample_en", int'(sample_en), 0);
    chk("bp_busy", int'(bus.busy), 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done("bp_release", NCH * LAT + 50);

    // random levels with random backpressure
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) vin[c] = $urandom_range(0, FS);
      go(1'b1, 0);
      t = 0;
      while ((bus.busy || bus.out_valid) && t < 3 * NCH * LAT) begin
        @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      bus.out_ready = 1'b1;
      wait_done("rand_scan", 3 * NCH * LAT);
    end

    // reset during bit 4 of a conversion
    vin[1] = 'h5A;
    go(1'b0, 1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_dac", int'(dac_code), ('h5A & 'hE0) | 'h10);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_dac", int'(dac_code), 0);
    chk("mid_rst_mux", int'(mux_sel), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    go(1'b0, 1);
    wait_done("post_rst", LAT + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
